// File: rtl/adma_pkg.sv
// Shared types for the AXI DMA data movers: the per-transaction descriptor
// carried from the transaction engine to a mover.
package adma_pkg;

  localparam int unsigned ADMA_MST_ID_W  = 5;
  localparam int unsigned ADMA_ATX_LEN_W = 8;

  typedef struct packed {
    logic [ADMA_MST_ID_W-1:0]  id;
    logic [ADMA_ATX_LEN_W-1:0] len;
  } adma_desc_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port. A push on a full
// FIFO is refused even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the counter alone.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/adma_dm_dst_axis.sv
// Destination-side AXI-Stream mover: frames DMA write-data beats with tid and
// tlast from queued descriptors and reports each finished transaction by ID.
module adma_dm_dst_axis
  import adma_pkg::*;
#(
  parameter int unsigned DMA_CHN_NUM      = 4,
  parameter int unsigned ATX_DST_DATA_W   = 256,
  parameter int unsigned ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
  parameter int unsigned DST_TDEST_W      = 2,
  parameter int unsigned MST_ID_W         = ADMA_MST_ID_W,
  parameter int unsigned ATX_LEN_W        = ADMA_ATX_LEN_W,
  parameter int unsigned ATX_NUM_OSTD     = DMA_CHN_NUM
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [MST_ID_W-1:0]         atx_awid,
  input  logic [ATX_LEN_W-1:0]        atx_awlen,
  input  logic                        atx_vld,
  output logic                        atx_rdy,
  input  logic [ATX_DST_DATA_W-1:0]   atx_wdata,
  input  logic [ATX_DST_BYTE_AMT-1:0] atx_wstrb,
  input  logic                        atx_wdata_vld,
  output logic                        atx_wdata_rdy,
  output logic [MST_ID_W-1:0]         atx_done_id,
  output logic                        atx_done_vld,
  output logic [DMA_CHN_NUM-1:0]      atx_dst_err,
  output logic [MST_ID_W-1:0]         m_tid_o,
  output logic [DST_TDEST_W-1:0]      m_tdest_o,
  output logic [ATX_DST_DATA_W-1:0]   m_tdata_o,
  output logic [ATX_DST_BYTE_AMT-1:0] m_tkeep_o,
  output logic [ATX_DST_BYTE_AMT-1:0] m_tstrb_o,
  output logic                        m_tlast_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a raised valid and its payload stay put until that transfer.

  adma_desc_t desc_in, head;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic       out_free, beat_acc, is_last;

  logic [ATX_LEN_W-1:0]        cnt_q, cnt_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic [MST_ID_W-1:0]         tid_q, tid_d;
  logic [ATX_DST_DATA_W-1:0]   tdata_q, tdata_d;
  logic [ATX_DST_BYTE_AMT-1:0] tkeep_q, tkeep_d;
  logic [ATX_DST_BYTE_AMT-1:0] tstrb_q, tstrb_d;
  logic                        done_vld_q, done_vld_d;
  logic [MST_ID_W-1:0]         done_id_q, done_id_d;

  assign desc_in = '{id: atx_awid, len: atx_awlen};

  sync_fifo #(
    .WIDTH ($bits(adma_desc_t)),
    .DEPTH (ATX_NUM_OSTD)
  ) u_desc_fifo (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .push_i  (atx_vld),
    .wdata_i (desc_in),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The output slot frees up in the same cycle its beat is taken downstream.
  assign out_free      = !tvalid_q || m_tready_i;
  assign atx_rdy       = !fifo_full;
  assign atx_wdata_rdy = !fifo_empty && out_free;
  assign beat_acc      = atx_wdata_vld && atx_wdata_rdy;
  assign is_last       = (cnt_q == head.len);
  assign fifo_pop      = beat_acc && is_last;

  always_comb begin
    cnt_d      = cnt_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tid_d      = tid_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tstrb_d    = tstrb_q;
    done_vld_d = tvalid_q && m_tready_i && tlast_q;
    done_id_d  = done_id_q;
    if (done_vld_d) done_id_d = tid_q;
    if (beat_acc) begin
      cnt_d    = is_last ? '0 : cnt_q + 1'b1;
      tvalid_d = 1'b1;
      tlast_d  = is_last;
      tid_d    = head.id;
      tdata_d  = atx_wdata;
      tkeep_d  = '1;
      tstrb_d  = atx_wstrb;
    end else if (m_tready_i) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q      <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tid_q      <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tstrb_q    <= '0;
      done_vld_q <= 1'b0;
      done_id_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tid_q      <= tid_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tstrb_q    <= tstrb_d;
      done_vld_q <= done_vld_d;
      done_id_q  <= done_id_d;
    end
  end

  assign m_tvalid_o   = tvalid_q;
  assign m_tlast_o    = tlast_q;
  assign m_tid_o      = tid_q;
  assign m_tdata_o    = tdata_q;
  assign m_tkeep_o    = tkeep_q;
  assign m_tstrb_o    = tstrb_q;
  assign m_tdest_o    = '0;
  assign atx_done_vld = done_vld_q;
  assign atx_done_id  = done_id_q;
  assign atx_dst_err  = '0;

endmodule

// File: tb/tb_adma_dm_dst_axis.sv
// Directed bench for adma_dm_dst_axis: descriptor/beat drivers, an expected
// beat queue checked on every stream handshake, and done-pulse tracking.
module tb_adma_dm_dst_axis;

  localparam int DW  = 256;
  localparam int BW  = DW / 8;
  localparam int IDW = 5;
  localparam int LW  = 8;
  localparam int CHN = 4;

  typedef logic [329:0] cmp_t;

  logic           aclk;
  logic           aresetn;
  logic [IDW-1:0] atx_awid;
  logic [LW-1:0]  atx_awlen;
  logic           atx_vld;
  logic           atx_rdy;
  logic [DW-1:0]  atx_wdata;
  logic [BW-1:0]  atx_wstrb;
  logic           atx_wdata_vld;
  logic           atx_wdata_rdy;
  logic [IDW-1:0] atx_done_id;
  logic           atx_done_vld;
  logic [CHN-1:0] atx_dst_err;
  logic [IDW-1:0] m_tid_o;
  logic [1:0]     m_tdest_o;
  logic [DW-1:0]  m_tdata_o;
  logic [BW-1:0]  m_tkeep_o;
  logic [BW-1:0]  m_tstrb_o;
  logic           m_tlast_o;
  logic           m_tvalid_o;
  logic           m_tready_i;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int base;
  bit hs_last_prev = 1'b0;

  logic [325:0]   exp_q[$];
  logic [IDW-1:0] exp_done_q[$];

  int t3_id[7]   = '{0, 1, 1, 2, 2, 2, 3};
  bit t3_last[7] = '{1, 0, 1, 0, 0, 1, 1};

  adma_dm_dst_axis dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .atx_awid      (atx_awid),
    .atx_awlen     (atx_awlen),
    .atx_vld       (atx_vld),
    .atx_rdy       (atx_rdy),
    .atx_wdata     (atx_wdata),
    .atx_wstrb     (atx_wstrb),
    .atx_wdata_vld (atx_wdata_vld),
    .atx_wdata_rdy (atx_wdata_rdy),
    .atx_done_id   (atx_done_id),
    .atx_done_vld  (atx_done_vld),
    .atx_dst_err   (atx_dst_err),
    .m_tid_o       (m_tid_o),
    .m_tdest_o     (m_tdest_o),
    .m_tdata_o     (m_tdata_o),
    .m_tkeep_o     (m_tkeep_o),
    .m_tstrb_o     (m_tstrb_o),
    .m_tlast_o     (m_tlast_o),
    .m_tvalid_o    (m_tvalid_o),
    .m_tready_i    (m_tready_i)
  );

  // Clock and watchdog
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    fail_now("global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic chk(input string tag, input cmp_t obs, input cmp_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic logic [DW-1:0] beat_data(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic check_reset(input string pfx);
    chk({pfx, "_tvalid"},   cmp_t'(m_tvalid_o),    cmp_t'(0));
    chk({pfx, "_tlast"},    cmp_t'(m_tlast_o),     cmp_t'(0));
    chk({pfx, "_tdata"},    cmp_t'(m_tdata_o),     cmp_t'(0));
    chk({pfx, "_tid"},      cmp_t'(m_tid_o),       cmp_t'(0));
    chk({pfx, "_tkeep"},    cmp_t'(m_tkeep_o),     cmp_t'(0));
    chk({pfx, "_tstrb"},    cmp_t'(m_tstrb_o),     cmp_t'(0));
    chk({pfx, "_done_vld"}, cmp_t'(atx_done_vld),  cmp_t'(0));
    chk({pfx, "_done_id"},  cmp_t'(atx_done_id),   cmp_t'(0));
    chk({pfx, "_wdata_rdy"},cmp_t'(atx_wdata_rdy), cmp_t'(0));
    chk({pfx, "_atx_rdy"},  cmp_t'(atx_rdy),       cmp_t'(1));
    chk({pfx, "_tdest"},    cmp_t'(m_tdest_o),     cmp_t'(0));
    chk({pfx, "_dst_err"},  cmp_t'(atx_dst_err),   cmp_t'(0));
  endtask

  // Drivers: called #1 after a rising edge, return #1 after the accepting edge.
  task automatic push_desc(input logic [IDW-1:0] id, input logic [LW-1:0] len);
    int waited = 0;
    atx_awid  = id;
    atx_awlen = len;
    atx_vld   = 1'b1;
    @(negedge aclk);
    while (!atx_rdy && waited < 300) begin
      @(negedge aclk);
      waited++;
    end
    if (!atx_rdy) fail_now("desc_timeout");
    @(posedge aclk);
    #1;
    atx_vld = 1'b0;
  endtask

  task automatic send_beat(input logic [IDW-1:0] id, input logic last,
                           input logic [DW-1:0] data, input logic [BW-1:0] strb);
    int waited = 0;
    atx_wdata     = data;
    atx_wstrb     = strb;
    atx_wdata_vld = 1'b1;
    @(negedge aclk);
    while (!atx_wdata_rdy && waited < 300) begin
      @(negedge aclk);
      waited++;
    end
    if (!atx_wdata_rdy) begin
      fail_now("wdata_timeout");
    end else begin
      exp_q.push_back({id, last, data, strb, {BW{1'b1}}});
      if (last) exp_done_q.push_back(id);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic drain_check(input string pfx, input int exp_done);
    atx_wdata_vld = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    chk({pfx, "_beats_left"}, cmp_t'(exp_q.size()),      cmp_t'(0));
    chk({pfx, "_done_left"},  cmp_t'(exp_done_q.size()), cmp_t'(0));
    chk({pfx, "_done_cnt"},   cmp_t'(done_cnt - base),   cmp_t'(exp_done));
  endtask

  // Scoreboard: every stream handshake and done pulse is matched in order.
  always @(negedge aclk) begin
    if (atx_done_vld || hs_last_prev)
      chk("done_timing", cmp_t'(atx_done_vld), cmp_t'(hs_last_prev));
    if (atx_done_vld) begin
      done_cnt++;
      if (exp_done_q.size() == 0) fail_now("done_unexpected");
      else chk("done_id", cmp_t'(atx_done_id), cmp_t'(exp_done_q.pop_front()));
    end
    if (m_tvalid_o && m_tready_i) begin
      if (exp_q.size() == 0) fail_now("beat_unexpected");
      else chk("beat", cmp_t'({m_tid_o, m_tlast_o, m_tdata_o, m_tstrb_o, m_tkeep_o}),
               cmp_t'(exp_q.pop_front()));
    end
    hs_last_prev = aresetn && m_tvalid_o && m_tready_i && m_tlast_o;
  end

  initial begin
    aresetn       = 1'b0;
    atx_awid      = '0;
    atx_awlen     = '0;
    atx_vld       = 1'b0;
    atx_wdata     = '0;
    atx_wstrb     = '0;
    atx_wdata_vld = 1'b0;
    m_tready_i    = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check_reset("rst");
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Single 4-beat burst, tready always high
    base = done_cnt;
    push_desc(5'd3, 8'd3);
    send_beat(5'd3, 1'b0, beat_data(1), {BW{1'b1}});
    send_beat(5'd3, 1'b0, beat_data(2), 32'hA5A5_A5A5);
    send_beat(5'd3, 1'b0, beat_data(3), {BW{1'b1}});
    send_beat(5'd3, 1'b1, beat_data(4), 32'h0000_FFFF);
    drain_check("t1", 1);

    // Same burst with a 5-cycle downstream stall after beat 2
    base = done_cnt;
    push_desc(5'd3, 8'd3);
    send_beat(5'd3, 1'b0, beat_data(11), {BW{1'b1}});
    send_beat(5'd3, 1'b0, beat_data(12), 32'h1234_5678);
    m_tready_i = 1'b0;
    atx_wdata  = beat_data(13);
    atx_wstrb  = {BW{1'b1}};
    repeat (5) begin
      @(negedge aclk);
      chk("stall_wdata_rdy", cmp_t'(atx_wdata_rdy), cmp_t'(0));
      chk("stall_tvalid",    cmp_t'(m_tvalid_o),    cmp_t'(1));
      chk("stall_tdata",     cmp_t'(m_tdata_o),     cmp_t'(beat_data(12)));
      chk("stall_tstrb",     cmp_t'(m_tstrb_o),     cmp_t'(32'h1234_5678));
    end
    @(posedge aclk);
    #1;
    m_tready_i = 1'b1;
    send_beat(5'd3, 1'b0, beat_data(13), {BW{1'b1}});
    send_beat(5'd3, 1'b1, beat_data(14), {BW{1'b1}});
    drain_check("t2", 1);

    // Fill the queue, then stream 7 beats across 4 transactions
    base = done_cnt;
    push_desc(5'd0, 8'd0);
    push_desc(5'd1, 8'd1);
    push_desc(5'd2, 8'd2);
    push_desc(5'd3, 8'd0);
    @(negedge aclk);
    chk("full_atx_rdy", cmp_t'(atx_rdy), cmp_t'(0));
    @(posedge aclk);
    #1;
    for (int i = 0; i < 7; i++)
      send_beat(IDW'(t3_id[i]), t3_last[i], beat_data(20 + i), BW'(32'h0F0F_0000 + i));
    drain_check("t3", 4);
    chk("t3_atx_rdy_after", cmp_t'(atx_rdy), cmp_t'(1));

    // Beats offered with no descriptor are held off
    base = done_cnt;
    atx_wdata     = beat_data(40);
    atx_wstrb     = {BW{1'b1}};
    atx_wdata_vld = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      chk("idle_wdata_rdy", cmp_t'(atx_wdata_rdy), cmp_t'(0));
      chk("idle_tvalid",    cmp_t'(m_tvalid_o),    cmp_t'(0));
    end
    @(posedge aclk);
    #1;
    atx_awid  = 5'd9;
    atx_awlen = 8'd0;
    atx_vld   = 1'b1;
    @(posedge aclk);
    #1;
    atx_vld = 1'b0;
    @(negedge aclk);
    chk("late_wdata_rdy", cmp_t'(atx_wdata_rdy), cmp_t'(1));
    chk("late_tvalid_n1", cmp_t'(m_tvalid_o),    cmp_t'(0));
    exp_q.push_back({5'd9, 1'b1, beat_data(40), {BW{1'b1}}, {BW{1'b1}}});
    exp_done_q.push_back(5'd9);
    @(posedge aclk);
    #1;
    atx_wdata_vld = 1'b0;
    @(negedge aclk);
    chk("late_tvalid_n2", cmp_t'(m_tvalid_o), cmp_t'(1));
    drain_check("t4", 1);

    // Longest burst: len=255 -> 256 beats
    base = done_cnt;
    push_desc(5'd7, 8'd255);
    for (int k = 0; k < 256; k++)
      send_beat(5'd7, (k == 255), beat_data(1000 + k), {BW{1'b1}} ^ BW'(k));
    drain_check("t5", 1);

    // Reset during beat 2 of a 4-beat burst
    base = done_cnt;
    push_desc(5'd5, 8'd3);
    send_beat(5'd5, 1'b0, beat_data(60), {BW{1'b1}});
    send_beat(5'd5, 1'b0, beat_data(61), {BW{1'b1}});
    aresetn       = 1'b0;
    atx_wdata_vld = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    #1;
    check_reset("mid_rst");
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("post_rst_atx_rdy",   cmp_t'(atx_rdy),          cmp_t'(1));
    chk("post_rst_no_done",   cmp_t'(done_cnt - base),  cmp_t'(0));
    chk("post_rst_tvalid",    cmp_t'(m_tvalid_o),       cmp_t'(0));
    push_desc(5'd6, 8'd1);
    send_beat(5'd6, 1'b0, beat_data(70), {BW{1'b1}});
    send_beat(5'd6, 1'b1, beat_data(71), 32'hFF00_FF00);
    drain_check("t6", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
